axi_rw_bridge: RTL
==================

# axi_rw_bridge

Parametrised AXI4 master bridge between the cache layer and the system bus: up to `NUM_RD` read clients (icache, dcache, future PTW/prefetch) share one AXI read channel through a round-robin arbiter, and one write client (dcache) drives the AW/W/B channels independently. It supports single-beat uncached accesses and multi-beat INCR cache-line bursts of configurable width, with one outstanding transaction per direction. It replaces the fixed two-client, 128-bit-line bus interface in the NPC memory path.

## Interface
- `NUM_RD`, 2, number of read clients; index = AXI ID
- `ADDR_W`, 64, address width
- `DATA_W`, 64, AXI data width (power of 2, ≥ 32)
- `LINE_W`, 128, cache line width; `BEATS = LINE_W/DATA_W` (power of 2, ≥ 1)
- `ID_W`, 4, AXI ID width, `2^ID_W ≥ NUM_RD`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `rd_req`  in  NUM_RD  per-client read request, held until `rd_ready`
- `rd_addr`  in  NUM_RD*ADDR_W  packed, client i at `[i*ADDR_W +: ADDR_W]`
- `rd_type`  in  NUM_RD*3  0..3 = 2^type bytes single beat; 4 = line burst; 5..7 = single full-width beat
- `rd_ready`  out  NUM_RD  one-hot, one-cycle accept pulse
- `rdata`  out  DATA_W  shared read data
- `rvalid`  out  NUM_RD  one-hot beat valid to owning client
- `rlast`  out  1  last beat qualifier
- `wr_req`, `wr_addr`, `wr_type`  in  1/ADDR_W/3  write request, same type encoding
- `wr_data`  in  LINE_W  beat k at `[k*DATA_W +: DATA_W]`
- `wr_strb`  in  DATA_W/8  strobe, single-beat writes only
- `wr_ready`  out  1  one-cycle accept pulse
- `wr_done`  out  1  one-cycle pulse on B handshake
- `ar*`, `r*`, `aw*`, `w*`, `b*`: full AXI4 master AR/R/AW/W/B signal sets (valid/ready, addr, id, len, size, burst, data, strb, last, resp)

## Operation
- Read FSM R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: if any `rd_req`, grant by round-robin: first requester strictly after `last_grant`. Pulse `rd_ready[g]`, latch addr/type/g, go to R_ADDR.
  - R_ADDR: `arvalid=1`; `arid=g`; `arlen = BEATS-1` for type 4, else 0; `arsize = type` for 0..3, else `log2(DATA_W/8)`; `arburst = INCR`. Leave on `arready`.
  - R_DATA: `rready=1`. Each R handshake drives `rdata = r data` and `rvalid[g]=1`, with `rlast` equal to AXI rlast. R handshake with rlast returns to R_IDLE.
- Write FSM W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: on `wr_req`, pulse `wr_ready`, latch addr/type/data/strb.
  - W_ADDR: `awvalid=1`, `awid=0`; len/size/burst encoded as for reads.
  - W_DATA: `wvalid=1`. Beat counter `wcnt` selects `wr_data[wcnt*DATA_W +: DATA_W]`. `wstrb` is all-ones for type 4, else the latched `wr_strb`. `wlast = (wcnt == len)`. Advance on `wready`.
  - W_RESP: `bready=1`; B handshake pulses `wr_done` and returns to W_IDLE.
- Read and write FSMs are fully independent; a read and a write may be in flight simultaneously.
- Request inputs are sampled only in the IDLE states. Changes outside IDLE are ignored.

## Timing
- Reset (`rst`=0, asynchronous): both FSMs IDLE, `last_grant = NUM_RD-1` (client 0 wins first), counters 0. All valid/ready/pulse outputs are 0 and data outputs are 0.
- Accept at cycle T (`rd_ready` high), `arvalid` high at T+1. `arvalid` and `awvalid` are registered and stay high until their handshake.
- `rdata`/`rvalid`/`rlast` are combinational from the R channel, so there is zero-cycle latency from beat to client. Clients cannot backpressure.
- The earliest next read accept is the cycle after the last-beat handshake. The same applies to the next write accept after the B handshake.
- Simultaneous requests from all clients: each is granted once per `NUM_RD` consecutive transactions, with no starvation.
- `wcnt` saturates at `len`. An extra `wready` after `wlast` is impossible because `wvalid` drops in W_RESP.
- Reset asserted mid-burst aborts the burst immediately. No completion pulse is issued.

## Configuration
- `AXI_RESP_ERR_EN` defined:
  - Adds outputs `rd_err` (NUM_RD) and `wr_err` (1).
  - `rd_err[g]` pulses with any beat whose `rresp[1]=1`, and also when `rid != g`.
  - `wr_err` pulses with `wr_done` when `bresp[1]=1`.
- Undefined: those ports are absent, and resp/ID fields are ignored.

## Test plan
- Client 1 type 4 read of 0x8000_0040, NUM_RD=2 → `arlen=1`, `arsize=3`, `arid=1`. Two beats delivered on `rvalid[1]`, with `rlast` on beat 2 only.
- Clients 0 and 1 request continuously for 4 transactions → grant order 0,1,0,1.
- Type 2 write of 0x1000_0004, data 0xDEADBEEF, strb 0xF0 → `awlen=0`, `awsize=2`, one W beat with `wlast=1` and `wstrb=0xF0`. `wr_done` fires one cycle-pulse on B handshake.
- Type 4 write concurrent with type 4 read, `arready`/`wready` randomly stalled → both complete with correct beat data; ordering is independent.
- Reset pulsed low during read beat 1 → all outputs 0 at once. After release, a fresh request is accepted with client 0 priority.
- With `AXI_RESP_ERR_EN`: beat with `rresp=2'b10` for client 0 → `rd_err[0]` high in that cycle only.

Source files
------------

// File: rtl/axi_rw_bridge.sv
// AXI4 master bridge: round-robin arbitrated read clients plus one write client.
// Define AXI_RESP_ERR_EN to add rd_err/wr_err response-error outputs.
module axi_rw_bridge #(
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LINE_W = 128,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*3-1:0]      rd_type,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic                     rlast,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [2:0]               wr_type,
    input  logic [LINE_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_strb,
    output logic                     wr_ready,
    output logic                     wr_done,
`ifdef AXI_RESP_ERR_EN
    output logic [NUM_RD-1:0]        rd_err,
    output logic                     wr_err,
`endif
    output logic                     arvalid,
    input  logic                     arready,
    output logic [ADDR_W-1:0]        araddr,
    output logic [ID_W-1:0]          arid,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     axi_rvalid,
    output logic                     rready,
    input  logic [DATA_W-1:0]        axi_rdata,
    input  logic [ID_W-1:0]          axi_rid,
    input  logic [1:0]               axi_rresp,
    input  logic                     axi_rlast,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [ID_W-1:0]          awid,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [DATA_W-1:0]        wdata,
    output logic [DATA_W/8-1:0]      wstrb,
    output logic                     wlast,
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [ID_W-1:0]          bid,
    input  logic [1:0]               bresp
);
    localparam int BEATS     = LINE_W / DATA_W;
    localparam int SIZE_FULL = $clog2(DATA_W / 8);
    localparam int GW        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    function automatic logic [7:0] enc_len(input logic [2:0] t);
        return (t == 3'd4) ? 8'(BEATS - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] enc_size(input logic [2:0] t);
        return (t < 3'd4) ? t : 3'(SIZE_FULL);
    endfunction

    rstate_t           r_state;
    wstate_t           w_state;
    logic [GW-1:0]     last_grant, rd_g, gnt;
    logic              found, any_req, r_beat;
    int                idx;
    logic [LINE_W-1:0] wline;
    logic [DATA_W/8-1:0] wstrb_q;
    logic              wfull;
    logic [CW-1:0]     wcnt;

    // Round-robin: first requester strictly after the previous grant.
    always_comb begin
        gnt   = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_RD; k++) begin
            idx = (int'(last_grant) + k) % NUM_RD;
            if (!found && rd_req[idx]) begin
                gnt   = GW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |rd_req;
    assign r_beat  = rready && axi_rvalid;
    assign rdata   = r_beat ? axi_rdata : '0;
    assign rlast   = r_beat && axi_rlast;

    always_comb begin
        rd_ready = '0;
        rvalid   = '0;
        if (rst && r_state == R_IDLE && any_req) rd_ready[gnt] = 1'b1;
        if (r_beat) rvalid[rd_g] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            last_grant <= GW'(NUM_RD - 1);
            rd_g       <= '0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arid       <= '0;
            arlen      <= '0;
            arsize     <= '0;
            arburst    <= '0;
            rready     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (any_req) begin
                    rd_g       <= gnt;
                    last_grant <= gnt;
                    araddr     <= rd_addr[gnt*ADDR_W +: ADDR_W];
                    arid       <= ID_W'(gnt);
                    arlen      <= enc_len(rd_type[gnt*3 +: 3]);
                    arsize     <= enc_size(rd_type[gnt*3 +: 3]);
                    arburst    <= 2'b01;
                    arvalid    <= 1'b1;
                    r_state    <= R_ADDR;
                end
                R_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    r_state <= R_DATA;
                end
                R_DATA: if (axi_rvalid && axi_rlast) begin
                    rready  <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write side: the line is held until the last beat; outputs gated by wvalid.
    assign wr_ready = rst && w_state == W_IDLE && wr_req;
    assign wr_done  = bready && bvalid;
    assign awid     = '0;
    assign wlast    = wvalid && (8'(wcnt) == awlen);
    assign wdata    = wvalid ? wline[wcnt*DATA_W +: DATA_W] : '0;
    assign wstrb    = !wvalid ? '0 : (wfull ? '1 : wstrb_q);

    always_ff @(posedge clk) begin
        if (wr_ready) begin
            wline   <= wr_data;
            wstrb_q <= wr_strb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
            wvalid  <= 1'b0;
            wfull   <= 1'b0;
            wcnt    <= '0;
            bready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (wr_req) begin
                    awaddr  <= wr_addr;
                    awlen   <= enc_len(wr_type);
                    awsize  <= enc_size(wr_type);
                    awburst <= 2'b01;
                    wfull   <= (wr_type == 3'd4);
                    wcnt    <= '0;
                    awvalid <= 1'b1;
                    w_state <= W_ADDR;
                end
                W_ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (wready) begin
                    if (wlast) begin
                        wvalid  <= 1'b0;
                        bready  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                W_RESP: if (bvalid) begin
                    bready  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXI_RESP_ERR_EN
    logic unused_resp;
    assign unused_resp = ^{axi_rresp[0], bresp[0], bid};
    assign wr_err      = wr_done && bresp[1];

    always_comb begin
        rd_err = '0;
        if (r_beat && (axi_rresp[1] || axi_rid != ID_W'(rd_g))) rd_err[rd_g] = 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{axi_rid, axi_rresp, bid, bresp};
`endif

endmodule
